// File: rtl/control_sequencer.sv
// control_sequencer: hardwired T0-T7 step sequencer for the MiniSRC datapath.
// Control lines are a pure decode of (step, IR opcode); memory steps stall on Mem_ready.
module control_sequencer #(
  parameter int OPCODE_W    = 5,
  parameter int CNT_W       = 16,
  parameter int MAX_INSTR   = 0,
  parameter int MEM_WAIT_EN = 1
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic [31:0]      IR,
  input  logic             Mem_ready,
  output logic             PCout,
  output logic             Zlowout,
  output logic             MDRout,
  output logic             HIout,
  output logic             LOout,
  output logic             InPortout,
  output logic             MARin,
  output logic             Zin,
  output logic             PCin,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             IncPC,
  output logic             Read,
  output logic             Write,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             Rin,
  output logic             Rout,
  output logic             BAout,
  output logic             Cout,
  output logic             CONin,
  output logic             OutPortin,
  output logic [2:0]       alu_op,
  output logic             Run,
  output logic             Fault,
  output logic [CNT_W-1:0] Instr_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_FAULT
  } state_t;

  localparam logic [2:0] ALU_NONE = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;

  localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(5'b00000);
  localparam logic [OPCODE_W-1:0] OP_LDI  = OPCODE_W'(5'b00001);
  localparam logic [OPCODE_W-1:0] OP_ST   = OPCODE_W'(5'b00010);
  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(5'b00011);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(5'b00100);
  localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(5'b00101);
  localparam logic [OPCODE_W-1:0] OP_OR   = OPCODE_W'(5'b00110);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(5'b01100);
  localparam logic [OPCODE_W-1:0] OP_ANDI = OPCODE_W'(5'b01101);
  localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(5'b01110);
  localparam logic [OPCODE_W-1:0] OP_BR   = OPCODE_W'(5'b10011);
  localparam logic [OPCODE_W-1:0] OP_JR   = OPCODE_W'(5'b10100);
  localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(5'b10101);
  localparam logic [OPCODE_W-1:0] OP_IN   = OPCODE_W'(5'b10110);
  localparam logic [OPCODE_W-1:0] OP_OUT  = OPCODE_W'(5'b10111);
  localparam logic [OPCODE_W-1:0] OP_MFHI = OPCODE_W'(5'b11000);
  localparam logic [OPCODE_W-1:0] OP_MFLO = OPCODE_W'(5'b11001);
  localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(5'b11010);
  localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(5'b11011);

  localparam bit WAIT_EN = (MEM_WAIT_EN != 0);

  state_t                state, next_state;
  logic [OPCODE_W-1:0]   opcode;
  logic [2:0]            alu_sel;
  logic                  mem_step, last_step, stall, retire, halt_now;
  logic [CNT_W-1:0]      count_inc;
  logic                  unused_ir;

  assign opcode    = IR[31 -: OPCODE_W];
  assign unused_ir = ^IR[31-OPCODE_W:0];

  always_comb begin
    case (opcode)
      OP_ADD, OP_ADDI: alu_sel = ALU_ADD;
      OP_SUB:          alu_sel = ALU_SUB;
      OP_AND, OP_ANDI: alu_sel = ALU_AND;
      OP_OR, OP_ORI:   alu_sel = ALU_OR;
      default:         alu_sel = ALU_NONE;
    endcase
  end

  assign count_inc = (Instr_count == '1) ? Instr_count : Instr_count + 1'b1;
  assign halt_now  = (MAX_INSTR != 0) && (count_inc == CNT_W'(MAX_INSTR));

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    {PCout, Zlowout, MDRout, HIout, LOout, InPortout, MARin, Zin, PCin, MDRin, IRin, Yin,
     IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, OutPortin} = '0;
    alu_op     = ALU_NONE;
    next_state = state;
    mem_step   = 1'b0;
    last_step  = 1'b0;
    case (state)
      S_IDLE: next_state = S_T0;
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; next_state = S_T1; end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        mem_step = 1'b1; next_state = S_T2;
      end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; next_state = S_T3; end
      S_T3: begin
        next_state = S_T4;
        case (opcode)
          OP_LD, OP_LDI, OP_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
            Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
          end
          OP_BR:   begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; last_step = 1'b1; end
          OP_JAL:  begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
          OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; last_step = 1'b1; end
          OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; last_step = 1'b1; end
          OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; last_step = 1'b1; end
          OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; last_step = 1'b1; end
          OP_NOP:  last_step = 1'b1;
          OP_HALT: next_state = S_HALT;
          default: next_state = S_FAULT;
        endcase
      end
      // Past T3 the opcode is already known legal; a step with no defined action
      // means IR changed mid-instruction, which is treated as a fault.
      S_T4: begin
        next_state = S_T5;
        case (opcode)
          OP_LD, OP_LDI, OP_ST: begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = alu_sel;
          end
          OP_ADDI, OP_ANDI, OP_ORI: begin Cout = 1'b1; Zin = 1'b1; alu_op = alu_sel; end
          OP_BR:   begin PCout = 1'b1; Yin = 1'b1; end
          OP_JAL:  begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; last_step = 1'b1; end
          default: next_state = S_FAULT;
        endcase
      end
      S_T5: begin
        next_state = S_T6;
        case (opcode)
          OP_LD, OP_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
          OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; last_step = 1'b1;
          end
          OP_BR:   begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; end
          default: next_state = S_FAULT;
        endcase
      end
      S_T6: begin
        next_state = S_T7;
        case (opcode)
          OP_LD:   begin Read = 1'b1; MDRin = 1'b1; mem_step = 1'b1; end
          OP_ST:   begin Gra = 1'b1; Rout = 1'b1; Write = 1'b1; mem_step = 1'b1; last_step = 1'b1; end
          OP_BR:   begin Zlowout = 1'b1; PCin = 1'b1; last_step = 1'b1; end
          default: next_state = S_FAULT;
        endcase
      end
      S_T7: begin
        if (opcode == OP_LD) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; last_step = 1'b1;
        end else begin
          next_state = S_FAULT;
        end
      end
      S_HALT, S_FAULT: next_state = state;
      default: next_state = S_IDLE;
    endcase

    if (stall) next_state = state;
    else if (last_step) next_state = halt_now ? S_HALT : S_T0;
  end

  assign stall  = mem_step && WAIT_EN && !Mem_ready;
  assign retire = last_step && !stall;
  assign Run    = state inside {S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7};
  assign Fault  = (state == S_FAULT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state       <= S_IDLE;
      Instr_count <= '0;
    end else begin
      state <= next_state;
      if (retire) Instr_count <= count_inc;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle expected control words are queued
// from an opcode step table and compared at each falling clock edge.
`timescale 1ns/1ps
module tb_control_sequencer;

  localparam int CW = 16;

  localparam logic [23:0] M_PCOUT = 24'h800000, M_ZLOWOUT = 24'h400000, M_MDROUT = 24'h200000;
  localparam logic [23:0] M_HIOUT = 24'h100000, M_LOOUT = 24'h080000, M_INPORTOUT = 24'h040000;
  localparam logic [23:0] M_MARIN = 24'h020000, M_ZIN = 24'h010000, M_PCIN = 24'h008000;
  localparam logic [23:0] M_MDRIN = 24'h004000, M_IRIN = 24'h002000, M_YIN = 24'h001000;
  localparam logic [23:0] M_INCPC = 24'h000800, M_READ = 24'h000400, M_WRITE = 24'h000200;
  localparam logic [23:0] M_GRA = 24'h000100, M_GRB = 24'h000080, M_GRC = 24'h000040;
  localparam logic [23:0] M_RIN = 24'h000020, M_ROUT = 24'h000010, M_BAOUT = 24'h000008;
  localparam logic [23:0] M_COUT = 24'h000004, M_CONIN = 24'h000002, M_OUTPORTIN = 24'h000001;

  typedef struct packed {
    logic          run;
    logic          fault;
    logic [2:0]    alu;
    logic [23:0]   ctl;
    logic [CW-1:0] cnt;
  } obs_t;

  typedef struct {
    obs_t        exp;
    logic [31:0] ir;
    logic        mr;
  } entry_t;

  typedef struct packed {
    logic [23:0] ctl;
    logic [2:0]  alu;
    logic        last;
    logic        mem;
  } step_t;

  logic          Clock = 1'b0, Clear = 1'b0, Mem_ready = 1'b1, sel = 1'b0;
  logic [31:0]   IR = '0;
  logic [23:0]   ctl_a, ctl_b;
  logic [2:0]    alu_a, alu_b;
  logic          run_a, run_b, fault_a, fault_b;
  logic [CW-1:0] cnt_a, cnt_b;
  obs_t          obs;

  entry_t sb[$];
  int     total = 0, bad = 0;
  int     model_cnt = 0, model_max = 0;
  bit     model_nowait = 1'b0;

  always #5 Clock = ~Clock;

  always_comb obs = sel ? {run_b, fault_b, alu_b, ctl_b, cnt_b} : {run_a, fault_a, alu_a, ctl_a, cnt_a};

  control_sequencer #(.OPCODE_W(5), .CNT_W(CW), .MAX_INSTR(0), .MEM_WAIT_EN(1)) dut_a (
    .Clock(Clock), .Clear(Clear), .IR(IR), .Mem_ready(Mem_ready),
    .PCout(ctl_a[23]), .Zlowout(ctl_a[22]), .MDRout(ctl_a[21]), .HIout(ctl_a[20]),
    .LOout(ctl_a[19]), .InPortout(ctl_a[18]), .MARin(ctl_a[17]), .Zin(ctl_a[16]),
    .PCin(ctl_a[15]), .MDRin(ctl_a[14]), .IRin(ctl_a[13]), .Yin(ctl_a[12]),
    .IncPC(ctl_a[11]), .Read(ctl_a[10]), .Write(ctl_a[9]), .Gra(ctl_a[8]),
    .Grb(ctl_a[7]), .Grc(ctl_a[6]), .Rin(ctl_a[5]), .Rout(ctl_a[4]),
    .BAout(ctl_a[3]), .Cout(ctl_a[2]), .CONin(ctl_a[1]), .OutPortin(ctl_a[0]),
    .alu_op(alu_a), .Run(run_a), .Fault(fault_a), .Instr_count(cnt_a)
  );

  control_sequencer #(.OPCODE_W(5), .CNT_W(CW), .MAX_INSTR(3), .MEM_WAIT_EN(0)) dut_b (
    .Clock(Clock), .Clear(Clear), .IR(IR), .Mem_ready(Mem_ready),
    .PCout(ctl_b[23]), .Zlowout(ctl_b[22]), .MDRout(ctl_b[21]), .HIout(ctl_b[20]),
    .LOout(ctl_b[19]), .InPortout(ctl_b[18]), .MARin(ctl_b[17]), .Zin(ctl_b[16]),
    .PCin(ctl_b[15]), .MDRin(ctl_b[14]), .IRin(ctl_b[13]), .Yin(ctl_b[12]),
    .IncPC(ctl_b[11]), .Read(ctl_b[10]), .Write(ctl_b[9]), .Gra(ctl_b[8]),
    .Grb(ctl_b[7]), .Grc(ctl_b[6]), .Rin(ctl_b[5]), .Rout(ctl_b[4]),
    .BAout(ctl_b[3]), .Cout(ctl_b[2]), .CONin(ctl_b[1]), .OutPortin(ctl_b[0]),
    .alu_op(alu_b), .Run(run_b), .Fault(fault_b), .Instr_count(cnt_b)
  );

  function automatic bit is_legal(input logic [4:0] op);
    return op inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd13, 5'd14,
                      5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25, 5'd26};
  endfunction

  function automatic logic [2:0] alu_of(input logic [4:0] op);
    case (op)
      5'b00011, 5'b01100: return 3'd1;
      5'b00100:           return 3'd2;
      5'b00101, 5'b01101: return 3'd3;
      5'b00110, 5'b01110: return 3'd4;
      default:            return 3'd0;
    endcase
  endfunction

  // Step table from T3 onward, organised by opcode.
  function automatic step_t model_step(input logic [4:0] op, input int t);
    step_t s;
    s = '0;
    case (op)
      5'b00000, 5'b00001, 5'b00010: begin
        case (t)
          3: s.ctl = M_GRB | M_BAOUT | M_YIN;
          4: begin s.ctl = M_COUT | M_ZIN; s.alu = 3'd1; end
          5: if (op == 5'b00001) begin s.ctl = M_ZLOWOUT | M_GRA | M_RIN; s.last = 1'b1; end
             else s.ctl = M_ZLOWOUT | M_MARIN;
          6: if (op == 5'b00010) begin s.ctl = M_GRA | M_ROUT | M_WRITE; s.mem = 1'b1; s.last = 1'b1; end
             else begin s.ctl = M_READ | M_MDRIN; s.mem = 1'b1; end
          default: begin s.ctl = M_MDROUT | M_GRA | M_RIN; s.last = 1'b1; end
        endcase
      end
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01100, 5'b01101, 5'b01110: begin
        case (t)
          3: s.ctl = M_GRB | M_ROUT | M_YIN;
          4: begin s.ctl = (op[3] ? M_COUT : (M_GRC | M_ROUT)) | M_ZIN; s.alu = alu_of(op); end
          default: begin s.ctl = M_ZLOWOUT | M_GRA | M_RIN; s.last = 1'b1; end
        endcase
      end
      5'b10011: begin
        case (t)
          3: s.ctl = M_GRA | M_ROUT | M_CONIN;
          4: s.ctl = M_PCOUT | M_YIN;
          5: begin s.ctl = M_COUT | M_ZIN; s.alu = 3'd1; end
          default: begin s.ctl = M_ZLOWOUT | M_PCIN; s.last = 1'b1; end
        endcase
      end
      5'b10101: begin
        if (t == 3) s.ctl = M_PCOUT | M_GRB | M_RIN;
        else begin s.ctl = M_GRA | M_ROUT | M_PCIN; s.last = 1'b1; end
      end
      5'b10100: begin s.ctl = M_GRA | M_ROUT | M_PCIN; s.last = 1'b1; end
      5'b10110: begin s.ctl = M_INPORTOUT | M_GRA | M_RIN; s.last = 1'b1; end
      5'b10111: begin s.ctl = M_GRA | M_ROUT | M_OUTPORTIN; s.last = 1'b1; end
      5'b11000: begin s.ctl = M_HIOUT | M_GRA | M_RIN; s.last = 1'b1; end
      5'b11001: begin s.ctl = M_LOOUT | M_GRA | M_RIN; s.last = 1'b1; end
      default:  s.last = 1'b1;
    endcase
    return s;
  endfunction

  task automatic push(input logic [23:0] ctl, input logic [2:0] alu, input logic run,
                      input logic fault, input logic [31:0] ir, input logic mr);
    entry_t e;
    e.exp = {run, fault, alu, ctl, CW'(model_cnt)};
    e.ir  = ir;
    e.mr  = model_nowait ? 1'b0 : mr;
    sb.push_back(e);
  endtask

  task automatic push_instr(input logic [4:0] op, input int t1_stall, input int mem_stall);
    logic [31:0] ir;
    step_t       s;
    ir = {op, 27'($urandom)};
    push(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 3'd0, 1'b1, 1'b0, ir, 1'($urandom));
    repeat (t1_stall) push(M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 3'd0, 1'b1, 1'b0, ir, 1'b0);
    push(M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 3'd0, 1'b1, 1'b0, ir, 1'b1);
    push(M_MDROUT | M_IRIN, 3'd0, 1'b1, 1'b0, ir, 1'($urandom));
    if (op == 5'b11011 || !is_legal(op)) begin
      push('0, 3'd0, 1'b1, 1'b0, ir, 1'($urandom));
      repeat (3) push('0, 3'd0, 1'b0, (op != 5'b11011), ir, 1'($urandom));
      return;
    end
    for (int t = 3; t <= 7; t++) begin
      s = model_step(op, t);
      if (s.mem) repeat (mem_stall) push(s.ctl, s.alu, 1'b1, 1'b0, ir, 1'b0);
      push(s.ctl, s.alu, 1'b1, 1'b0, ir, s.mem ? 1'b1 : 1'($urandom));
      if (s.last) break;
    end
    if (model_cnt < (1 << CW) - 1) model_cnt++;
    if (model_max != 0 && model_cnt == model_max)
      repeat (3) push('0, 3'd0, 1'b0, 1'b0, ir, 1'($urandom));
  endtask

  task automatic reset_dut();
    Clear = 1'b0;
    Mem_ready = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    IR = (sb.size() > 0) ? sb[0].ir : 32'h0;
    Clear = 1'b1;
  endtask

  task automatic test_reset();
    Clear = 1'b0;
    repeat (3) begin
      IR = $urandom;
      Mem_ready = 1'($urandom);
      @(negedge Clock);
      for (int s = 0; s < 2; s++) begin
        sel = s[0];
        #1;
        total++;
        if (obs !== obs_t'(0)) begin
          bad++;
          $display("FAIL reset dut%0d: got %h expected %h", s, obs, obs_t'(0));
        end
      end
    end
    sel = 1'b0;
  endtask

  // addi then nop, finishing with halt: the halt must not be counted.
  task automatic test_addi_halt();
    entry_t e;
    int     n = 0;
    sel = 1'b0; model_nowait = 1'b0; model_max = 0; model_cnt = 0;
    push_instr(5'b01100, 0, 0);
    push_instr(5'b11010, 0, 0);
    push_instr(5'b11011, 0, 0);
    reset_dut();
    while (sb.size() > 0) begin
      @(negedge Clock);
      e = sb.pop_front();
      total++;
      if (obs !== e.exp) begin
        bad++;
        $display("FAIL addi_halt step %0d: got %h expected %h", n, obs, e.exp);
      end
      IR = e.ir; Mem_ready = e.mr; n++;
    end
  endtask

  task automatic test_ld_stall();
    entry_t e;
    int     n = 0;
    sel = 1'b0; model_nowait = 1'b0; model_max = 0; model_cnt = 0;
    push_instr(5'b00000, 0, 3);
    push_instr(5'b11011, 0, 0);
    reset_dut();
    while (sb.size() > 0) begin
      @(negedge Clock);
      e = sb.pop_front();
      total++;
      if (obs !== e.exp) begin
        bad++;
        $display("FAIL ld_stall step %0d: got %h expected %h", n, obs, e.exp);
      end
      IR = e.ir; Mem_ready = e.mr; n++;
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] ops [18] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd13,
                             5'd14, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25, 5'd26};
    entry_t e;
    int     n = 0;
    sel = 1'b0; model_nowait = 1'b0; model_max = 0; model_cnt = 0;
    for (int r = 0; r < 2; r++)
      foreach (ops[i]) push_instr(ops[i], $urandom_range(0, 2), $urandom_range(0, 2));
    push_instr(5'b11011, 1, 0);
    reset_dut();
    while (sb.size() > 0) begin
      @(negedge Clock);
      e = sb.pop_front();
      total++;
      if (obs !== e.exp) begin
        bad++;
        $display("FAIL back_to_back step %0d: got %h expected %h", n, obs, e.exp);
      end
      IR = e.ir; Mem_ready = e.mr; n++;
    end
  endtask

  // st stalled in T6 with Write high, then Clear asserted between clock edges.
  task automatic test_st_clear();
    entry_t e;
    int     n = 0;
    sel = 1'b0; model_nowait = 1'b0; model_max = 0; model_cnt = 0;
    push_instr(5'b11010, 0, 0);
    push_instr(5'b00010, 0, 3);
    reset_dut();
    while (sb.size() > 2) begin
      @(negedge Clock);
      e = sb.pop_front();
      total++;
      if (obs !== e.exp) begin
        bad++;
        $display("FAIL st_stall step %0d: got %h expected %h", n, obs, e.exp);
      end
      IR = e.ir; Mem_ready = e.mr; n++;
    end
    sb.delete();
    #2 Clear = 1'b0;
    #1;
    total++;
    if (obs !== obs_t'(0)) begin
      bad++;
      $display("FAIL st_clear_async: got %h expected %h", obs, obs_t'(0));
    end
  endtask

  task automatic test_fault();
    logic [4:0] bad_ops [2] = '{5'b11111, 5'b00111};
    entry_t e;
    sel = 1'b0; model_nowait = 1'b0; model_max = 0;
    foreach (bad_ops[k]) begin
      model_cnt = 0;
      push_instr(5'b11010, 0, 0);
      push_instr(bad_ops[k], 0, 0);
      reset_dut();
      while (sb.size() > 0) begin
        @(negedge Clock);
        e = sb.pop_front();
        total++;
        if (obs !== e.exp) begin
          bad++;
          $display("FAIL fault op=%b: got %h expected %h", bad_ops[k], obs, e.exp);
        end
        IR = e.ir; Mem_ready = e.mr;
      end
      #2 Clear = 1'b0;
      #1;
      total++;
      if (obs !== obs_t'(0)) begin
        bad++;
        $display("FAIL fault_clear op=%b: got %h expected %h", bad_ops[k], obs, obs_t'(0));
      end
    end
  endtask

  // Second instance: Mem_ready ignored and halt after three retires.
  task automatic test_no_wait_max();
    logic [4:0] prog [3][3] = '{'{5'd3, 5'd3, 5'd3}, '{5'd26, 5'd26, 5'd26}, '{5'd0, 5'd2, 5'd26}};
    entry_t e;
    int     n;
    sel = 1'b1; model_nowait = 1'b1; model_max = 3;
    foreach (prog[p]) begin
      model_cnt = 0; n = 0;
      foreach (prog[p][i]) push_instr(prog[p][i], 0, 0);
      reset_dut();
      while (sb.size() > 0) begin
        @(negedge Clock);
        e = sb.pop_front();
        total++;
        if (obs !== e.exp) begin
          bad++;
          $display("FAIL no_wait_max prog%0d step %0d: got %h expected %h", p, n, obs, e.exp);
        end
        IR = e.ir; Mem_ready = e.mr; n++;
      end
    end
    sel = 1'b0; model_nowait = 1'b0; model_max = 0;
  endtask

  initial begin
    test_reset();
    test_addi_halt();
    test_ld_stall();
    test_back_to_back();
    test_st_clear();
    test_fault();
    test_no_wait_max();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
